// File: rtl/clockgen_param_pkg.sv
// Shared defaults, the ST-compatible timing preset and the bus-cycle phase helper
// used by the clock generator and anything that needs to predict its phase chain.
package clockgen_param_pkg;

    localparam int DEF_NDIV        = 3;
    localparam int DEF_CYC_LEN     = 16;
    localparam int DEF_NPHASE      = 8;
    localparam int DEF_ADDRSEL_TAP = 5;
    localparam int DEF_CYCSEL_TAP  = 7;
    localparam int DEF_LATCH_TAP   = 1;

    typedef struct packed {
        logic [7:0] cyc_len;
        logic [7:0] nphase;
        logic [7:0] addrsel_tap;
        logic [7:0] cycsel_tap;
        logic [7:0] latch_tap;
    } preset_t;

    localparam preset_t ST_PRESET = '{
        cyc_len:     8'(DEF_CYC_LEN),
        nphase:      8'(DEF_NPHASE),
        addrsel_tap: 8'(DEF_ADDRSEL_TAP),
        cycsel_tap:  8'(DEF_CYCSEL_TAP),
        latch_tap:   8'(DEF_LATCH_TAP)
    };

    // Tap k is high for the half cycle starting k ticks after the cycle start.
    function automatic logic phase_active(input int unsigned cnt,
                                          input int unsigned k,
                                          input int unsigned len);
        int unsigned lag;
        lag = (cnt + len - k) % len;
        return lag < (len / 2);
    endfunction

endpackage

// File: rtl/clockgen_param_clkdiv_chain.sv
// Free-running binary divider: registered divided levels plus one-tick enables
// marking the tick in which dcnt[k:0] is all ones.
module clockgen_param_clkdiv_chain #(
    parameter int NDIV = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    output logic [NDIV-1:0] div,
    output logic [NDIV-1:0] div_en,
    output logic [NDIV-1:0] div_en_nxt
);

    logic [NDIV-1:0] dcnt_q, dcnt_d;
    logic [NDIV-1:0] div_en_q, div_en_d;

    always_comb begin
        dcnt_d = dcnt_q + NDIV'(1);
        if (clr) begin
            dcnt_d = '0;
        end
    end

    genvar gi;
    for (gi = 0; gi < NDIV; gi++) begin : g_en
        assign div_en_d[gi] = &dcnt_d[gi:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q   <= '0;
            div_en_q <= '0;
        end else begin
            dcnt_q   <= dcnt_d;
            div_en_q <= div_en_d;
        end
    end

    assign div        = dcnt_q;
    assign div_en     = div_en_q;
    assign div_en_nxt = div_en_d;

endmodule

// File: rtl/clockgen_param.sv
// Bus-cycle timing generator: divider enables, phase chain, cycsel/latch strobes,
// a CPU speed switch that only moves on cycle boundaries, and genlock resync.
module clockgen_param
    import clockgen_param_pkg::*;
#(
    parameter int NDIV        = DEF_NDIV,
    parameter int CYC_LEN     = DEF_CYC_LEN,
    parameter int NPHASE      = DEF_NPHASE,
    parameter int ADDRSEL_TAP = DEF_ADDRSEL_TAP,
    parameter int CYCSEL_TAP  = DEF_CYCSEL_TAP,
    parameter int LATCH_TAP   = DEF_LATCH_TAP
) (
    input  logic                       clk32,
    input  logic                       resb,
    input  logic                       turbo,
    input  logic                       resync,
    output logic [NDIV-1:0]            div,
    output logic [NDIV-1:0]            div_en,
    output logic                       cpu_en,
    output logic                       turbo_act,
    output logic [$clog2(CYC_LEN)-1:0] cyc_cnt,
    output logic                       cyc_start,
    output logic [NPHASE-1:0]          phase_time,
    output logic                       addrsel,
    output logic                       cycsel,
    output logic                       cycsel_en,
    output logic                       latch
);

    localparam int CW = $clog2(CYC_LEN);
    localparam logic [CW-1:0] CYC_LAST = CW'(CYC_LEN - 1);

    logic [CW-1:0]     cyc_cnt_q, cyc_cnt_d;
    logic              cyc_start_q, cyc_start_d;
    logic [NPHASE-1:0] time_q, time_d;
    logic              cycsel_q, cycsel_d;
    logic              latch_q, latch_d;
    logic              turbo_act_q, turbo_act_d;
    logic              cpu_en_q, cpu_en_d;
    logic              at_last;
    logic              resync_eff;
    logic [NDIV-1:0]   div_en_nxt;

    // Resync at tick 0 is ignored so the cycle is never stretched.
    assign at_last    = (cyc_cnt_q == CYC_LAST);
    assign resync_eff = resync && (cyc_cnt_q != '0);

    clockgen_param_clkdiv_chain #(
        .NDIV(NDIV)
    ) u_clkdiv_chain (
        .clk        (clk32),
        .rst_n      (resb),
        .clr        (resync_eff),
        .div        (div),
        .div_en     (div_en),
        .div_en_nxt (div_en_nxt)
    );

    always_comb begin
        cyc_cnt_d   = cyc_cnt_q + CW'(1);
        turbo_act_d = turbo_act_q;
        if (resync_eff || at_last) begin
            cyc_cnt_d   = '0;
            turbo_act_d = turbo;
        end
        cyc_start_d = (cyc_cnt_d == '0);
        cycsel_d    = time_q[CYCSEL_TAP];
        latch_d     = time_q[ADDRSEL_TAP] & ~time_q[LATCH_TAP];
    end

    // Select on the post-edge speed so a switch never splits or doubles a pulse.
    always_comb begin
        cpu_en_d = turbo_act_d ? div_en_nxt[0] : div_en_nxt[1];
    end

    genvar gi;
    for (gi = 0; gi < NPHASE; gi++) begin : g_phase
        assign time_d[gi] = phase_active(32'(cyc_cnt_d), gi, CYC_LEN);
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            cyc_cnt_q   <= '0;
            cyc_start_q <= 1'b1;
            time_q      <= '0;
            cycsel_q    <= 1'b0;
            latch_q     <= 1'b0;
            turbo_act_q <= 1'b0;
            cpu_en_q    <= 1'b0;
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            cyc_start_q <= cyc_start_d;
            time_q      <= time_d;
            cycsel_q    <= cycsel_d;
            latch_q     <= latch_d;
            turbo_act_q <= turbo_act_d;
            cpu_en_q    <= cpu_en_d;
        end
    end

    assign cyc_cnt    = cyc_cnt_q;
    assign cyc_start  = cyc_start_q;
    assign phase_time = time_q;
    assign addrsel    = time_q[ADDRSEL_TAP];
    assign cycsel     = cycsel_q;
    assign cycsel_en  = time_q[CYCSEL_TAP] & ~cycsel_q;
    assign latch      = latch_q;
    assign turbo_act  = turbo_act_q;
    assign cpu_en     = cpu_en_q;

endmodule

// File: tb/tb_clockgen_param.sv
// Randomised bench for clockgen_param: default 16-tick instance against a cycle-level
// model, plus a 24-tick / 12-phase instance checked for period and phase width.
module tb_clockgen_param;
    import clockgen_param_pkg::*;

    localparam int LEN_A = 16;
    localparam int NPH_A = 8;
    localparam int LEN_B = 24;
    localparam int NPH_B = 12;

    logic clk32 = 1'b0;
    logic resb;
    logic turbo;
    logic resync;
    logic resync_b;

    logic [2:0]  div_a, div_en_a;
    logic        cpu_en_a, turbo_act_a, cyc_start_a, addrsel_a, cycsel_a, cycsel_en_a, latch_a;
    logic [3:0]  cyc_cnt_a;
    logic [7:0]  time_a;

    logic [2:0]  div_b, div_en_b;
    logic        cpu_en_b, turbo_act_b, cyc_start_b, addrsel_b, cycsel_b, cycsel_en_b, latch_b;
    logic [4:0]  cyc_cnt_b;
    logic [11:0] time_b;

    always #5 clk32 = ~clk32;

    clockgen_param dut_a (
        .clk32(clk32), .resb(resb), .turbo(turbo), .resync(resync),
        .div(div_a), .div_en(div_en_a), .cpu_en(cpu_en_a), .turbo_act(turbo_act_a),
        .cyc_cnt(cyc_cnt_a), .cyc_start(cyc_start_a), .phase_time(time_a),
        .addrsel(addrsel_a), .cycsel(cycsel_a), .cycsel_en(cycsel_en_a), .latch(latch_a)
    );

    clockgen_param #(.CYC_LEN(LEN_B), .NPHASE(NPH_B)) dut_b (
        .clk32(clk32), .resb(resb), .turbo(turbo), .resync(resync_b),
        .div(div_b), .div_en(div_en_b), .cpu_en(cpu_en_b), .turbo_act(turbo_act_b),
        .cyc_cnt(cyc_cnt_b), .cyc_start(cyc_start_b), .phase_time(time_b),
        .addrsel(addrsel_b), .cycsel(cycsel_b), .cycsel_en(cycsel_en_b), .latch(latch_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: position in cycle, ticks since divider clear, speed, history.
    int pos, dc, tact, first, prev_cs, prev_lt, posb, firstb, tick, last_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (tick %0d)", tag, obs, exp, tick);
    endtask

    function automatic logic [15:0] model_phase(input int p, input int f, input int len, input int nph);
        logic [15:0] v;
        v = '0;
        if (f == 0) begin
            for (int k = 0; k < nph; k++) begin
                v[k] = ((((p - k) % len) + len) % len) < (len / 2);
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        pos = 0; dc = 0; tact = 0; first = 1; prev_cs = 0; prev_lt = 0;
        posb = 0; firstb = 1; last_en = -1;
    endtask

    task automatic model_edge();
        logic [15:0] t;
        t = model_phase(pos, first, LEN_A, NPH_A);
        prev_cs = int'(t[7]);
        prev_lt = (first == 0 && phase_active(pos, 5, LEN_A) && !phase_active(pos, 1, LEN_A)) ? 1 : 0;
        if (resync && pos != 0) begin
            pos = 0; dc = 0; tact = int'(turbo);
        end else begin
            dc = (dc + 1) % 8;
            if (pos == LEN_A - 1) begin
                pos = 0; tact = int'(turbo);
            end else begin
                pos++;
            end
        end
        first = 0;
        posb = (posb + 1) % LEN_B;
        firstb = 0;
        tick++;
    endtask

    task automatic check_all();
        logic [15:0] t, tb_v;
        logic en0, en1, en2;
        t    = model_phase(pos, first, LEN_A, NPH_A);
        tb_v = model_phase(posb, firstb, LEN_B, NPH_B);
        en0 = (dc % 2) == 1;
        en1 = (dc % 4) == 3;
        en2 = (dc % 8) == 7;
        chk("cyc_cnt",   64'(cyc_cnt_a),   64'(pos));
        chk("cyc_start", 64'(cyc_start_a), 64'(pos == 0));
        chk("time",      64'(time_a),      64'(t[7:0]));
        chk("addrsel",   64'(addrsel_a),   64'(t[5]));
        chk("cycsel",    64'(cycsel_a),    64'(prev_cs));
        chk("cycsel_en", 64'(cycsel_en_a), 64'(t[7] && prev_cs == 0));
        chk("latch",     64'(latch_a),     64'(prev_lt));
        chk("div",       64'(div_a),       64'(dc));
        chk("div_en",    64'(div_en_a),    64'({en2, en1, en0}));
        chk("turbo_act", 64'(turbo_act_a), 64'(tact));
        chk("cpu_en",    64'(cpu_en_a),    64'((tact != 0) ? en0 : en1));
        chk("cyc_cnt_b",   64'(cyc_cnt_b),   64'(posb));
        chk("cyc_start_b", 64'(cyc_start_b), 64'(posb == 0));
        chk("time_b",      64'(time_b),      64'(tb_v[11:0]));
        if (cpu_en_a === 1'b1) begin
            if (last_en >= 0) chk("en_gap", 64'((tick - last_en) >= 2), 64'(1));
            last_en = tick;
        end
    endtask

    task automatic step();
        @(posedge clk32);
        if (resb) model_edge();
        #1;
        check_all();
        $display("tick %0d rst %b tu %b rs %b | a cyc %0d time %h cs %b/%b lt %b cpu %b ta %b div %h | b cyc %0d time %h cs %b/%b lt %b cpu %b ta %b div %h/%h st %b as %b",
                 tick, resb, turbo, resync, cyc_cnt_a, time_a, cycsel_a, cycsel_en_a, latch_a,
                 cpu_en_a, turbo_act_a, div_a, cyc_cnt_b, time_b, cycsel_b, cycsel_en_b, latch_b,
                 cpu_en_b, turbo_act_b, div_b, div_en_b, cyc_start_b, addrsel_b);
    endtask

    task automatic pulse_reset(input int hold);
        resb = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (hold) step();
        resb = 1'b1;
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < 2 * LEN_A && pos != target; i++) step();
    endtask

    initial begin
        resb = 1'b0; turbo = 1'b0; resync = 1'b0; resync_b = 1'b0;
        tick = 0;
        model_reset();
        repeat (2) step();
        resb = 1'b1;

        // Default timing at slow speed.
        repeat (40) step();

        // Speed request mid-cycle takes effect only at the wrap.
        wait_pos(5);
        turbo = 1'b1;
        repeat (24) step();

        // Genlock resync mid-cycle.
        wait_pos(9);
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("resync_time",  64'(time_a),      64'h01);
        chk("resync_start", 64'(cyc_start_a), 64'(1));
        repeat (20) step();

        // Resync at tick 0 and at the wrap tick.
        wait_pos(0);
        resync = 1'b1;
        step();
        resync = 1'b0;
        wait_pos(15);
        turbo = 1'b0;
        resync = 1'b1;
        step();
        resync = 1'b0;
        repeat (10) step();

        // Asynchronous reset in the middle of a cycle.
        wait_pos(11);
        pulse_reset(2);
        repeat (20) step();

        // Randomised speed changes, resyncs and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) == 0) turbo = ~turbo;
            resync = ($urandom_range(11) == 0);
            if ($urandom_range(199) == 0) begin
                resync = 1'b0;
                pulse_reset(int'($urandom_range(3, 1)));
            end
            step();
        end
        resync = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
